// File: rtl/amstrad_io_replay.sv
// Replays queued Amstrad I/O register writes onto io_A/io_D/io_WR after winning the bus.
// Each entry is encoded at enqueue. A lost grant aborts the write, and the entry is retried in full.
module amstrad_io_replay #(
    parameter int WR_CYCLES  = 4,
    parameter int GAP_CYCLES = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_type,
    input  logic [7:0]  req_data,
    input  logic [15:0] req_addr,
    output logic        bus_req,
    input  logic        bus_ack,
    output logic [15:0] io_A,
    output logic [7:0]  io_D,
    output logic        io_WR,
    output logic        busy,
    output logic        wr_done,
    output logic        req_err
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam int CMAX = (WR_CYCLES > GAP_CYCLES) ? WR_CYCLES : GAP_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_SETUP,
        S_WRITE,
        S_GAP,
        S_RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic [23:0]       mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [CNTW-1:0]   cnt_q;
    logic [15:0]       io_a_q;
    logic [7:0]        io_d_q;
    logic              req_err_q;

    logic [23:0]       enc_d;
    logic              full, empty, accept, push, pop;
    logic              last_wr, last_gap, load_ad;

    assign full     = (cnt_q == CNTW'(FIFO_DEPTH));
    assign empty    = (cnt_q == '0);
    assign accept   = req_valid && req_ready;
    assign push     = accept && (req_type != 2'd3);
    assign last_wr  = (cyc_q == CW'(WR_CYCLES - 1));
    assign last_gap = (cyc_q == CW'(GAP_CYCLES - 1));
    // The head retires only on a write that finished with the grant still held.
    assign pop      = (state_q == S_WRITE) && bus_ack && last_wr;
    assign load_ad  = (state_d == S_SETUP) && (state_q != S_SETUP);

    always_comb begin
        enc_d = {req_addr, req_data};
        case (req_type)
            2'd0:    enc_d = {(req_data[6] ? 16'h7E00 : 16'h7F00), 2'b11, req_data[5:0]};
            2'd1:    enc_d = {16'hDF00, req_data};
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (!empty) state_d = S_REQ;
            S_REQ:     if (bus_ack) state_d = S_SETUP;
            S_SETUP:   state_d = bus_ack ? S_WRITE : S_REQ;
            S_WRITE: begin
                if (!bus_ack)     state_d = S_REQ;
                else if (last_wr) state_d = S_GAP;
            end
            S_GAP:     if (last_gap) state_d = empty ? S_RELEASE : S_SETUP;
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        cyc_d = (state_d != state_q) ? '0 : cyc_q + CW'(1);
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wptr_q] <= enc_d;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cyc_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            io_a_q    <= '0;
            io_d_q    <= '0;
            req_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            req_err_q <= accept && (req_type == 2'd3);
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNTW'(1);
                2'b01:   cnt_q <= cnt_q - CNTW'(1);
                default: ;
            endcase
            if (load_ad) {io_a_q, io_d_q} <= mem_q[rptr_q];
        end
    end

    assign req_ready = !full;
    assign bus_req   = (state_q == S_REQ) || (state_q == S_SETUP) ||
                       (state_q == S_WRITE) || (state_q == S_GAP);
    assign io_WR     = (state_q == S_WRITE);
    assign io_A      = io_a_q;
    assign io_D      = io_d_q;
    assign busy      = (state_q != S_IDLE) || !empty;
    assign wr_done   = pop;
    assign req_err   = req_err_q;

endmodule

// File: tb/tb_amstrad_io_replay.sv
// Directed and randomized checks of amstrad_io_replay against an encoding/order model.
module tb_amstrad_io_replay;

    localparam int WR  = 4;
    localparam int GAP = 2;
    localparam int PER = 1 + WR + GAP;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_type = 2'd0;
    logic [7:0]  req_data = 8'd0;
    logic [15:0] req_addr = 16'd0;
    logic        bus_req;
    logic        bus_ack = 1'b0;
    logic [15:0] io_A;
    logic [7:0]  io_D;
    logic        io_WR;
    logic        busy;
    logic        wr_done;
    logic        req_err;

    amstrad_io_replay #(.WR_CYCLES(WR), .GAP_CYCLES(GAP), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_type(req_type), .req_data(req_data), .req_addr(req_addr),
        .bus_req(bus_req), .bus_ack(bus_ack), .io_A(io_A), .io_D(io_D),
        .io_WR(io_WR), .busy(busy), .wr_done(wr_done), .req_err(req_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Bus-side observer: strobe rises, pulse widths, completions, ownership drops.
    logic [23:0] rise_q[$];
    int          rise_t[$];
    int          width_q[$];
    logic [23:0] done_q[$];
    int          breq_falls = 0;
    int          stab_err = 0;
    int          wcnt = 0;
    logic [23:0] held = '0;
    logic        prev_wr = 1'b0;
    logic        prev_breq = 1'b0;

    always @(negedge CLK) begin
        if (io_WR && !prev_wr) begin
            rise_q.push_back({io_A, io_D});
            rise_t.push_back(cyc);
            wcnt = 1;
            held = {io_A, io_D};
        end else if (io_WR) begin
            wcnt++;
            if ({io_A, io_D} !== held) stab_err++;
        end else if (prev_wr) begin
            width_q.push_back(wcnt);
        end
        if (wr_done) done_q.push_back({io_A, io_D});
        if (!bus_req && prev_breq) breq_falls++;
        prev_wr   = io_WR;
        prev_breq = bus_req;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] enc(input logic [1:0] t, input logic [7:0] d, input logic [15:0] a);
        if (t == 2'd0) return {(d[6] ? 16'h7E00 : 16'h7F00), 2'b11, d[5:0]};
        if (t == 2'd1) return {16'hDF00, d};
        return {a, d};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [1:0] t, input logic [7:0] d, input logic [15:0] a);
        req_valid = 1'b1;
        req_type  = t;
        req_data  = d;
        req_addr  = a;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((busy || bus_req) && k < budget) begin
            tick();
            k++;
        end
        chk("idle_timeout", {31'd0, busy | bus_req}, 32'd0);
    endtask

    task automatic wait_wr(input int budget);
        int k = 0;
        while (!io_WR && k < budget) begin
            tick();
            k++;
        end
        chk("wr_timeout", {31'd0, io_WR}, 32'd1);
    endtask

    initial begin
        int r0, d0, f0, b0, s0, w0, t_ack;
        logic [23:0] exp_q[$];
        logic [23:0] e;
        logic [1:0]  rt;
        logic [7:0]  rd;
        logic [15:0] ra;
        int n;

        // Reset state
        repeat (3) tick();
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busreq", {31'd0, bus_req}, 32'd0);
        chk("rst_wr", {31'd0, io_WR}, 32'd0);
        chk("rst_ad", {8'd0, io_A, io_D}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pulses", {30'd0, wr_done, req_err}, 32'd0);
        reset = 1'b0;
        tick();

        // Single ROM select with grant already held
        bus_ack = 1'b1;
        r0 = rise_q.size(); d0 = done_q.size(); w0 = width_q.size(); b0 = breq_falls;
        push(2'd1, 8'h07, 16'h0000);
        wait_idle(60);
        chk("t1_rises", rise_q.size() - r0, 1);
        chk("t1_ad", rise_q[r0], 24'hDF0007);
        chk("t1_width", width_q[w0], WR);
        chk("t1_done", done_q.size() - d0, 1);
        chk("t1_breq_falls", breq_falls - b0, 1);
        chk("t1_busy", {31'd0, busy}, 32'd0);

        // RAM config with expansion bit set
        r0 = rise_q.size();
        push(2'd0, 8'h55, 16'h0000);
        wait_idle(60);
        chk("t2_ad", rise_q[r0], 24'h7E00D5);

        // Four random entries, grant withheld then given
        bus_ack = 1'b0;
        exp_q.delete();
        r0 = rise_q.size(); d0 = done_q.size(); w0 = width_q.size();
        b0 = breq_falls; s0 = stab_err;
        for (int i = 0; i < 4; i++) begin
            rt = 2'($urandom_range(0, 2));
            rd = 8'($urandom);
            ra = 16'($urandom);
            exp_q.push_back(enc(rt, rd, ra));
            push(rt, rd, ra);
        end
        chk("t3_full", {31'd0, req_ready}, 32'd0);
        chk("t3_breq_wait", {31'd0, bus_req}, 32'd1);
        repeat (9) tick();
        bus_ack = 1'b1;
        t_ack = cyc;
        wait_idle(100);
        chk("t3_rises", rise_q.size() - r0, 4);
        chk("t3_first_rise", rise_t[r0] - t_ack, 2);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_ad%0d", i), rise_q[r0 + i], exp_q[i]);
            chk($sformatf("t3_done%0d", i), done_q[d0 + i], exp_q[i]);
            chk($sformatf("t3_width%0d", i), width_q[w0 + i], WR);
            if (i > 0) chk($sformatf("t3_period%0d", i), rise_t[r0 + i] - rise_t[r0 + i - 1], PER);
        end
        chk("t3_breq_falls", breq_falls - b0, 1);
        chk("t3_stable", stab_err - s0, 0);

        // Grant lost in the second strobe cycle
        r0 = rise_q.size(); d0 = done_q.size();
        rd = 8'($urandom);
        ra = 16'($urandom);
        e = enc(2'd2, rd, ra);
        push(2'd2, rd, ra);
        wait_wr(20);
        tick();
        chk("t4_wr2", {31'd0, io_WR}, 32'd1);
        bus_ack = 1'b0;
        tick();
        chk("t4_wr_drop", {31'd0, io_WR}, 32'd0);
        chk("t4_rereq", {31'd0, bus_req}, 32'd1);
        chk("t4_no_done", done_q.size() - d0, 0);
        repeat (5) tick();
        bus_ack = 1'b1;
        wait_idle(60);
        chk("t4_rises", rise_q.size() - r0, 2);
        chk("t4_retry_ad", rise_q[r0 + 1], e);
        chk("t4_retry_width", width_q[width_q.size() - 1], WR);
        chk("t4_done", done_q.size() - d0, 1);
        chk("t4_done_ad", done_q[d0], e);

        // Reserved type is dropped
        b0 = breq_falls;
        push(2'd3, 8'hAA, 16'h1234);
        chk("t5_err", {31'd0, req_err}, 32'd1);
        tick();
        chk("t5_err_clr", {31'd0, req_err}, 32'd0);
        repeat (3) tick();
        chk("t5_busreq", {31'd0, bus_req}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);

        // Reset during a write with a second entry queued
        r0 = rise_q.size(); d0 = done_q.size();
        push(2'd1, 8'h01, 16'h0000);
        push(2'd1, 8'h02, 16'h0000);
        wait_wr(20);
        reset = 1'b1;
        tick();
        chk("t6_wr", {31'd0, io_WR}, 32'd0);
        chk("t6_busreq", {31'd0, bus_req}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_ready", {31'd0, req_ready}, 32'd1);
        reset = 1'b0;
        repeat (20) tick();
        chk("t6_rises", rise_q.size() - r0, 1);
        chk("t6_done", done_q.size() - d0, 0);

        // Random bursts including reserved requests
        for (int round = 0; round < 4; round++) begin
            exp_q.delete();
            d0 = done_q.size();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                rt = 2'($urandom_range(0, 3));
                rd = 8'($urandom);
                ra = 16'($urandom);
                if (rt != 2'd3) exp_q.push_back(enc(rt, rd, ra));
                push(rt, rd, ra);
            end
            wait_idle(100);
            chk($sformatf("r%0d_count", round), done_q.size() - d0, exp_q.size());
            for (int i = 0; i < exp_q.size() && d0 + i < done_q.size(); i++)
                chk($sformatf("r%0d_ad%0d", round, i), done_q[d0 + i], exp_q[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
